// File: rtl/mgia_pkg.sv
// mgia_pkg: shared FSM encoding, SRAM idle strobes and write-pulse rule for the video RAM arbiter.
package mgia_pkg;
  typedef enum logic [1:0] {IDLE, VID, CPU, DONE} state_t;
  localparam logic OE_N_IDLE = 1'b1;
  localparam logic WE_N_IDLE = 1'b1;
  localparam logic [1:0] BE_N_IDLE = 2'b11;
  // c is the down-counter value for the cycle; the access starts at ws and ends at 0
  function automatic logic we_low(input logic [2:0] ws, input logic [2:0] c);
    return ws >= 3'd2 ? (c != 3'd0 && c != ws) : (c == 3'd0);
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin tie-break; req[0] is video, req[1] is CPU.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;
  assign gnt = &req ? (last ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b0;
    else if (en && |req) last <= gnt[1];
endmodule

// File: rtl/video_ram_arbiter.sv
// video_ram_arbiter: shares one asynchronous-read SRAM between the read-only video fetch port and a CPU port.
module video_ram_arbiter
  import mgia_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [13:1] V_ADR_I,
  input  logic        V_CYC_I,
  input  logic        V_STB_I,
  output logic [15:0] V_DAT_O,
  output logic        V_ACK_O,
  input  logic [13:1] C_ADR_I,
  input  logic [15:0] C_DAT_I,
  output logic [15:0] C_DAT_O,
  input  logic        C_WE_I,
  input  logic [1:0]  C_SEL_I,
  input  logic        C_CYC_I,
  input  logic        C_STB_I,
  output logic        C_ACK_O,
  output logic [12:0] SRAM_ADR_O,
  input  logic [15:0] SRAM_DAT_I,
  output logic [15:0] SRAM_DAT_O,
  output logic        SRAM_DOE_O,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic [1:0]  SRAM_BE_N
);
  localparam logic [2:0] WS = 3'(WAIT_STATES);
  state_t      state;
  logic [2:0]  cnt, cnt_nx;
  logic        we, g_we;
  logic [1:0]  req, gnt;
  assign req    = {C_CYC_I & C_STB_I, V_CYC_I & V_STB_I};
  assign g_we   = gnt[1] & C_WE_I;
  assign cnt_nx = cnt - 3'd1;
  rr_arbiter2 u_arb (
    .clk   (CLK_I),
    .rst_n (RST_I),
    .en    (state == IDLE),
    .req   (req),
    .gnt   (gnt)
  );
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      state      <= IDLE;
      cnt        <= '0;
      we         <= 1'b0;
      V_ACK_O    <= 1'b0;
      C_ACK_O    <= 1'b0;
      V_DAT_O    <= '0;
      C_DAT_O    <= '0;
      SRAM_OE_N  <= OE_N_IDLE;
      SRAM_WE_N  <= WE_N_IDLE;
      SRAM_BE_N  <= BE_N_IDLE;
      SRAM_DOE_O <= 1'b0;
      SRAM_ADR_O <= '0;
      SRAM_DAT_O <= '0;
    end else begin
      V_ACK_O <= 1'b0;
      C_ACK_O <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          state      <= gnt[1] ? CPU : VID;
          cnt        <= WS;
          we         <= g_we;
          SRAM_ADR_O <= gnt[1] ? C_ADR_I : V_ADR_I;
          if (gnt[1]) SRAM_DAT_O <= C_DAT_I;
          SRAM_OE_N  <= g_we;
          SRAM_DOE_O <= g_we;
          SRAM_BE_N  <= g_we ? ~C_SEL_I : 2'b00;
          SRAM_WE_N  <= ~(g_we && we_low(WS, WS));
        end
        VID, CPU: if (cnt == 3'd0) begin
          state      <= DONE;
          SRAM_OE_N  <= OE_N_IDLE;
          SRAM_WE_N  <= WE_N_IDLE;
          SRAM_BE_N  <= BE_N_IDLE;
          SRAM_DOE_O <= 1'b0;
          // a master that dropped CYC still lets the SRAM cycle finish but gets no ACK or data
          if (state == VID && V_CYC_I) begin
            V_ACK_O <= 1'b1;
            V_DAT_O <= SRAM_DAT_I;
          end
          if (state == CPU && C_CYC_I) begin
            C_ACK_O <= 1'b1;
            C_DAT_O <= SRAM_DAT_I;
          end
        end else begin
          cnt       <= cnt_nx;
          SRAM_WE_N <= ~(we && we_low(WS, cnt_nx));
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/video_ram_arbiter.md
VIDEO_RAM_ARBITER -- requirements
Module: video_ram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1: extra SRAM cycles per access, legal range 0..7.
REQ-002 SHALL have port CLK_I  input  1  the single clock for all logic (25 MHz video clock).
REQ-003 SHALL have port RST_I  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports V_ADR_I in 13 [13:1], V_CYC_I in 1, V_STB_I in 1, V_DAT_O out 16, V_ACK_O out 1: read-only video master port, connected to the MGIA fetch bus.
REQ-005 SHALL have ports C_ADR_I in 13 [13:1], C_DAT_I in 16, C_DAT_O out 16, C_WE_I in 1, C_SEL_I in 2, C_CYC_I in 1, C_STB_I in 1, C_ACK_O out 1: CPU read/write master port.
REQ-006 SHALL have ports SRAM_ADR_O out 13, SRAM_DAT_I in 16, SRAM_DAT_O out 16, SRAM_DOE_O out 1 (drive data), SRAM_OE_N out 1, SRAM_WE_N out 1, SRAM_BE_N out 2: single-port SRAM with asynchronous reads.

Function
REQ-007 SHALL use a four-state FSM: IDLE, VID, CPU, DONE.
REQ-008 In IDLE, a request (CYC&STB) SHALL move the FSM to VID or CPU on the next edge and latch the address, write data, SEL and WE of the granted master.
REQ-009 On simultaneous requests, the grant SHALL go to the master not served last; after reset, video counts as served last, so the CPU wins the first tie.
REQ-010 A lone request SHALL be granted immediately, whatever the last-served state.
REQ-011 In VID/CPU, the FSM SHALL drive SRAM_ADR_O from the latched address and hold there for WAIT_STATES+1 cycles, using a 3-bit down-counter.
REQ-012 Read: SRAM_OE_N=0 and SRAM_BE_N=2'b00 for the whole access.
REQ-013 Write: SRAM_DOE_O=1 and SRAM_BE_N=~latched SEL for the whole access; SRAM_WE_N=0 for every cycle except the first and last when WAIT_STATES>=2, otherwise for the last cycle only.
REQ-014 On the last access cycle, the FSM SHALL register SRAM_DAT_I into the granted master's DAT_O, go to DONE, and assert that master's ACK_O for exactly one cycle.
REQ-015 DONE SHALL always return to IDLE, so each access costs WAIT_STATES+3 cycles from request to the cycle after ACK.
REQ-016 A master that keeps STB asserted SHALL be re-arbitrated in IDLE (no burst lock).
REQ-017 If CYC is deasserted mid-access, the access SHALL still complete on the SRAM, and ACK SHALL be suppressed while CYC=0.
REQ-018 V_DAT_O/C_DAT_O SHALL hold their last value until the next ACK to the same port.
REQ-019 C_WE_I asserted on the video port is not possible; V_* accesses SHALL always be reads.
REQ-020 Address arithmetic is none; the 13-bit address SHALL pass straight through, with no wrap handling needed.

Reset
REQ-021 While RST_I=0: FSM=IDLE, counter=0, last_served=video, V_ACK_O=C_ACK_O=0, V_DAT_O=C_DAT_O=16'h0000, SRAM_OE_N=SRAM_WE_N=1, SRAM_BE_N=2'b11, SRAM_DOE_O=0, SRAM_ADR_O=0, SRAM_DAT_O=0.
REQ-022 Reset asserted mid-access SHALL abort it immediately with no ACK; after release, the first decision SHALL be taken in IDLE on the first CLK_I edge.

Structure
REQ-023 FSM state encoding and the SRAM strobe idle constants SHALL live in the shared package mgia_pkg.
REQ-024 The tie-break SHALL be a sub-module rr_arbiter2 (2 requests, last-served flop, 2-bit one-hot grant); everything else stays flat.

Verification
REQ-025 Video read, WAIT_STATES=1, SRAM holds 16'hA5C3 at 13'h0040: V_ACK_O high exactly on cycle 4 after STB, with V_DAT_O=16'hA5C3.
REQ-026 CPU write of 16'h1234 to 13'h0001 with SEL=2'b10: SRAM_BE_N=2'b01 and SRAM_WE_N low for exactly one cycle; a following CPU read returns 16'h12xx, with the low byte unchanged.
REQ-027 Both masters hold STB from reset for 4 accesses: grant order CPU, VID, CPU, VID, with no ACK lost.
REQ-028 Video holds STB alone for 40 words: 40 ACKs in 40*(WAIT_STATES+3) cycles, with addresses in order.
REQ-029 CPU drops CYC during its SRAM access: C_ACK_O is never asserted, and the next video request is served normally.
REQ-030 RST_I pulled low in the VID state: all outputs take their REQ-021 values asynchronously, there is no V_ACK_O, and the first grant after release goes to the CPU on a tie.
